// File: rtl/ws_pe_feeder.sv
// Sequencer for one weight-stationary PE: buffers activations, issues the weight load,
// streams the vector and returns its dot product as the PE accumulator delta.
module ws_pe_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [DATA_WIDTH-1:0]   w_data,

    input  logic                    act_valid,
    output logic                    act_ready,
    input  logic [DATA_WIDTH-1:0]   act_data,
    input  logic                    act_last,

    output logic                    pe_load_w,
    output logic [DATA_WIDTH-1:0]   pe_w,
    output logic                    pe_valid,
    output logic [DATA_WIDTH-1:0]   pe_a,
    input  logic [2*DATA_WIDTH-1:0] pe_accum,

    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2*DATA_WIDTH-1:0] res_data,
    output logic [CNT_W-1:0]        res_count,

    output logic                    busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        CAPTURE,
        RESULT
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   w_reg;
    logic [RW-1:0]           base;
    logic [CNT_W-1:0]        cnt;
    logic [RW-1:0]           res_data_reg;
    logic [CNT_W-1:0]        res_count_reg;

    logic [DATA_WIDTH:0]     fifo_mem [FIFO_DEPTH];
    logic [AW:0]             wr_ptr;
    logic [AW:0]             rd_ptr;
    logic [DATA_WIDTH:0]     head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [RW-1:0] wrap_sub(input logic [RW-1:0] a, input logic [RW-1:0] b);
        return a - b;
    endfunction

    // Activation FIFO: extra pointer bit separates full from empty when indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = fifo_mem[rd_ptr[AW-1:0]];

    assign act_ready  = rst_n & ~fifo_full;
    assign push       = act_valid & act_ready;
    assign pe_valid   = (state == STREAM) & ~fifo_empty;
    assign pop        = pe_valid;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {act_last, act_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Sequencer: the base is sampled in LOAD, before any beat of this vector reaches the PE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            w_reg         <= '0;
            base          <= '0;
            cnt           <= '0;
            res_data_reg  <= '0;
            res_count_reg <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (w_valid) begin
                        w_reg <= w_data;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    base  <= pe_accum;
                    cnt   <= '0;
                    state <= STREAM;
                end
                STREAM: begin
                    if (pop) begin
                        cnt <= sat_inc(cnt);
                        if (head[DATA_WIDTH]) begin
                            state <= CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    res_data_reg  <= wrap_sub(pe_accum, base);
                    res_count_reg <= cnt;
                    state         <= RESULT;
                end
                RESULT: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign w_ready   = rst_n & (state == IDLE);
    assign pe_load_w = (state == LOAD);
    assign pe_w      = w_reg;
    assign pe_a      = pe_valid ? head[DATA_WIDTH-1:0] : '0;
    assign res_valid = (state == RESULT);
    assign res_data  = res_data_reg;
    assign res_count = res_count_reg;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ws_pe_feeder.sv
// Scoreboard bench for ws_pe_feeder with a behavioural PE and a dot-product reference model.
module tb_ws_pe_feeder;

    logic        clk;
    logic        rst_n;
    logic        w_valid;
    logic        w_ready;
    logic [15:0] w_data;
    logic        act_valid;
    logic        act_ready;
    logic [15:0] act_data;
    logic        act_last;
    logic        pe_load_w;
    logic [15:0] pe_w;
    logic        pe_valid;
    logic [15:0] pe_a;
    logic [31:0] pe_accum;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [7:0]  res_count;
    logic        busy;

    ws_pe_feeder #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data), .act_last(act_last),
        .pe_load_w(pe_load_w), .pe_w(pe_w), .pe_valid(pe_valid), .pe_a(pe_a), .pe_accum(pe_accum),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_count(res_count),
        .busy(busy)
    );

    typedef struct {
        logic [31:0] d;
        logic [7:0]  c;
    } res_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          wk      = 0;
    int          rr_mode = 1;
    int          act_hs  = 0;
    res_t        exp_res[$];
    logic [15:0] exp_a[$];
    logic [15:0] ab_d[300];
    logic        ab_l[300];
    int          ab_n = 0;

    logic [31:0] pe_acc_m;
    logic [15:0] pe_w_m;
    logic        preload_req = 1'b0;
    logic [31:0] preload_val = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural PE: weight register plus a never-clearing accumulator.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_acc_m <= 32'h0;
            pe_w_m   <= 16'h0;
        end else begin
            if (preload_req) pe_acc_m <= preload_val;
            else if (pe_valid) pe_acc_m <= pe_acc_m + 32'(pe_w_m) * 32'(pe_a);
            if (pe_load_w) pe_w_m <= pe_w;
        end
    end
    assign pe_accum = pe_acc_m;

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endfunction

    // Reference: dot product of a vector with plain modulo-2^32 arithmetic.
    task automatic expect_vec(input logic [15:0] w, input int start, input int n);
        res_t        e;
        logic [31:0] s;
        s = 32'h0;
        for (int i = 0; i < n; i++) s = s + 32'(w) * 32'(ab_d[start + i]);
        e.d = s;
        e.c = (n > 255) ? 8'd255 : 8'(n);
        exp_res.push_back(e);
    endtask

    task automatic set_ab(input int n, input logic [15:0] a0, input logic [15:0] a1,
                          input logic [15:0] a2);
        ab_n = n;
        ab_d[0] = a0; ab_d[1] = a1; ab_d[2] = a2;
        for (int i = 0; i < n; i++) ab_l[i] = (i == n - 1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       res_ready = 1'b0;
                1:       res_ready = 1'b1;
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every PE beat and every result handshake is checked against the queues.
    initial begin
        res_t        e;
        logic        hold_v;
        logic [31:0] hold_d;
        logic [7:0]  hold_c;
        hold_v = 1'b0;
        hold_d = 32'h0;
        hold_c = 8'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 1'b0;
            end else begin
                if (pe_valid) begin
                    chk("load_valid_overlap", 64'(pe_load_w), 64'(0));
                    if (exp_a.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got pe_a=%0h, expected no beat", pe_a);
                    end else begin
                        chk("pe_a", 64'(pe_a), 64'(exp_a.pop_front()));
                    end
                end
                if (res_valid) begin
                    if (hold_v) begin
                        chk("res_hold_data", 64'(res_data), 64'(hold_d));
                        chk("res_hold_count", 64'(res_count), 64'(hold_c));
                    end
                    if (res_ready) begin
                        hold_v = 1'b0;
                        if (exp_res.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_result: got %0h, expected none", res_data);
                        end else begin
                            e = exp_res.pop_front();
                            chk("res_data", 64'(res_data), 64'(e.d));
                            chk("res_count", 64'(res_count), 64'(e.c));
                        end
                    end else begin
                        hold_v = 1'b1;
                        hold_d = res_data;
                        hold_c = res_count;
                    end
                end else begin
                    hold_v = 1'b0;
                end
            end
        end
    end

    task automatic push_w(input logic [15:0] d);
        int t;
        t = 0;
        @(negedge clk);
        w_valid = 1'b1;
        w_data  = d;
        while (!w_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!w_ready) begin
            chk("w_accept_timeout", 64'(0), 64'(1));
            w_valid = 1'b0;
            return;
        end
        wk = cyc;
        @(posedge clk);
        #1;
        w_valid = 1'b0;
    endtask

    task automatic push_acts(input int gap_max);
        int t;
        for (int i = 0; i < ab_n; i++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
            @(negedge clk);
            act_valid = 1'b1;
            act_data  = ab_d[i];
            act_last  = ab_l[i];
            t = 0;
            while (!act_ready && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (!act_ready) begin
                chk("act_accept_timeout", 64'(0), 64'(1));
                act_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            act_valid = 1'b0;
            act_hs++;
            exp_a.push_back(ab_d[i]);
        end
    endtask

    task automatic wait_res();
        int t;
        t = 0;
        @(negedge clk);
        while (!res_valid && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!res_valid) chk("res_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_res.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_results", 64'(exp_res.size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] w;
        rst_n     = 1'b0;
        w_valid   = 1'b0;
        w_data    = 16'h0;
        act_valid = 1'b0;
        act_data  = 16'h0;
        act_last  = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_pe_valid", 64'(pe_valid), 64'(0));
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_pe_load_w", 64'(pe_load_w), 64'(0));
        chk("rst_res_data", 64'(res_data), 64'(0));
        rst_n = 1'b1;
        #1;
        chk("rst_w_ready", 64'(w_ready), 64'(1));
        chk("rst_act_ready", 64'(act_ready), 64'(1));

        // Basic dot product with prefilled activations.
        set_ab(3, 16'd1, 16'd2, 16'd3);
        expect_vec(16'd4, 0, 3);
        push_acts(0);
        push_w(16'd4);
        @(negedge clk);
        chk("basic_load", 64'(pe_load_w), 64'(1));
        chk("basic_load_novalid", 64'(pe_valid), 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("basic_valid", 64'(pe_valid), 64'(1));
            chk("basic_pe_a", 64'(pe_a), 64'(i + 1));
            chk("basic_load_once", 64'(pe_load_w), 64'(0));
        end
        @(negedge clk);
        chk("basic_capture_novalid", 64'(pe_valid), 64'(0));
        @(negedge clk);
        chk("basic_res_valid", 64'(res_valid), 64'(1));
        chk("basic_latency", 64'(cyc - wk), 64'(6));
        chk("basic_res_data", 64'(res_data), 64'(24));
        chk("basic_res_count", 64'(res_count), 64'(3));

        // Second vector: result is the accumulator delta, not its total.
        set_ab(2, 16'd2, 16'd2, 16'd0);
        expect_vec(16'd5, 0, 2);
        push_acts(0);
        push_w(16'd5);
        wait_res();
        chk("offset_res_data", 64'(res_data), 64'(20));
        chk("offset_accum", 64'(pe_acc_m), 64'(44));

        // Starved stream: second activation arrives after a gap.
        push_w(16'd3);
        set_ab(1, 16'd7, 16'd0, 16'd0);
        ab_l[0] = 1'b0;
        push_acts(0);
        @(negedge clk);
        chk("starve_first_beat", 64'(pe_valid), 64'(1));
        repeat (5) begin
            @(negedge clk);
            chk("starve_gap_valid", 64'(pe_valid), 64'(0));
            chk("starve_gap_busy", 64'(busy), 64'(1));
        end
        ab_d[0] = 16'd1;
        ab_l[0] = 1'b1;
        begin
            res_t e;
            e.d = 32'd24;
            e.c = 8'd2;
            exp_res.push_back(e);
        end
        push_acts(0);
        wait_res();
        chk("starve_res_data", 64'(res_data), 64'(24));
        chk("starve_res_count", 64'(res_count), 64'(2));

        // Wrap arithmetic near the top of the accumulator range.
        @(negedge clk);
        @(negedge clk);
        preload_req = 1'b1;
        preload_val = 32'hFFFF_FF00;
        @(negedge clk);
        preload_req = 1'b0;
        set_ab(2, 16'hFFFF, 16'h0002, 16'h0);
        expect_vec(16'hFFFF, 0, 2);
        push_acts(0);
        push_w(16'hFFFF);
        wait_res();
        chk("wrap_res_data", 64'(res_data), 64'(32'hFFFE0001 + 32'h0001FFFE));

        // Backpressure: result held while the FIFO fills behind it.
        rr_mode = 0;
        set_ab(3, 16'd1, 16'd2, 16'd3);
        expect_vec(16'd2, 0, 3);
        push_acts(0);
        push_w(16'd2);
        wait_res();
        ab_n = 6;
        for (int i = 0; i < 6; i++) begin
            ab_d[i] = 16'(i + 4);
            ab_l[i] = (i == 2) || (i == 5);
        end
        expect_vec(16'd1, 0, 3);
        expect_vec(16'd3, 3, 3);
        act_hs = 0;
        fork
            push_acts(0);
            begin
                repeat (10) begin
                    @(negedge clk);
                    chk("bp_w_ready", 64'(w_ready), 64'(0));
                    chk("bp_res_valid", 64'(res_valid), 64'(1));
                    chk("bp_res_data", 64'(res_data), 64'(12));
                end
                chk("bp_act_ready", 64'(act_ready), 64'(0));
                chk("bp_accepted", 64'(act_hs), 64'(4));
                rr_mode = 1;
                push_w(16'd1);
                push_w(16'd3);
            end
        join
        drain();

        // Randomized vectors, including one longer than the count saturates at.
        rr_mode = 2;
        for (int v = 0; v < 25; v++) begin
            n = $urandom_range(1, 7);
            w = 16'($urandom);
            ab_n = n;
            for (int i = 0; i < n; i++) begin
                ab_d[i] = 16'($urandom);
                ab_l[i] = (i == n - 1);
            end
            expect_vec(w, 0, n);
            fork
                push_acts(2);
                push_w(w);
            join
        end
        ab_n = 260;
        for (int i = 0; i < 260; i++) begin
            ab_d[i] = 16'd1;
            ab_l[i] = (i == 259);
        end
        expect_vec(16'd1, 0, 260);
        fork
            push_acts(0);
            push_w(16'd1);
        join
        drain();

        // Reset in the middle of streaming, then a clean vector.
        rr_mode = 1;
        set_ab(3, 16'd1, 16'd2, 16'd3);
        expect_vec(16'd2, 0, 3);
        push_acts(0);
        push_w(16'd2);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pe_valid", 64'(pe_valid), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_res_valid", 64'(res_valid), 64'(0));
        chk("mid_rst_pe_w", 64'(pe_w), 64'(0));
        chk("mid_rst_pe_a", 64'(pe_a), 64'(0));
        chk("mid_rst_res_data", 64'(res_data), 64'(0));
        exp_a.delete();
        exp_res.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_act_ready", 64'(act_ready), 64'(1));
        chk("post_rst_w_ready", 64'(w_ready), 64'(1));
        set_ab(2, 16'd3, 16'd4, 16'd0);
        expect_vec(16'd5, 0, 2);
        push_w(16'd5);
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_fifo_empty", 64'(pe_valid), 64'(0));
        end
        push_acts(0);
        drain();
        chk("leftover_beats", 64'(exp_a.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
